pcie_dll_tx_replay: RTL and testbench

- Transmit-side Data Link Layer engine.
- Takes Transaction Layer TLPs, prepends a 12-bit sequence number and appends a 32-bit LCRC. Default output is 12+224+32 = 268 bits.
- Keeps every transmitted TLP in a parametrised replay buffer until an ACK DLLP releases it. Replays on NAK or on replay-timer expiry.
- Sits between the TL TLP generator and the physical-layer framer; consumes received ACK/NAK DLLPs.

---
 rtl/pcie_dll_tx_replay.sv | 223 ++++++++++++++++++++++
 tb/tb_pcie_dll_tx_replay.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_dll_tx_replay.sv
`default_nettype none
// ============================================================================
//  Module   : pcie_dll_tx_replay
//  Function : PCIe DLL transmit path - sequence/LCRC framing and replay buffer
//  Revision : 1.0  initial release
// ============================================================================
module pcie_dll_tx_replay #(
    parameter int  TLP_W          = 224,
    parameter int  SEQ_W          = 12,
    parameter int  DEPTH          = 8,
    parameter int  REPLAY_TIMEOUT = 256,
    localparam int DLL_W          = TLP_W + SEQ_W + 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tl_valid,
    output logic                   tl_ready,
    input  logic [TLP_W-1:0]       tl_tlp,
    output logic                   dll_valid,
    input  logic                   dll_ready,
    output logic [DLL_W-1:0]       dll_tlp,
    input  logic                   dllp_valid,
    input  logic [47:0]            dllp,
    output logic [SEQ_W-1:0]       next_seq,
    output logic [SEQ_W-1:0]       acked_seq,
    output logic [$clog2(DEPTH):0] buf_count,
    output logic [1:0]             replay_num,
    output logic                   link_retrain,
    output logic                   dllp_err
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CW    = c_AW + 1;
    localparam int c_TW    = $clog2(REPLAY_TIMEOUT + 1);
    localparam int c_MSG_W = SEQ_W + TLP_W;
    localparam logic [31:0]     c_POLY        = 32'h04C1_1DB7;
    localparam logic [c_CW-1:0] c_DEPTH_CNT   = c_CW'(DEPTH);
    localparam logic [c_TW-1:0] c_TIMER_LAST  = c_TW'(REPLAY_TIMEOUT - 1);
    localparam logic [0:0]      c_ST_NORMAL   = 1'b0;
    localparam logic [0:0]      c_ST_REPLAY   = 1'b1;

    // CRC-32, MSB first, init all-ones, no reflection, inverted result
    function automatic logic [31:0] f_lcrc(input logic [c_MSG_W-1:0] msg);
        logic [31:0] crc;
        crc = 32'hFFFF_FFFF;
        for (int i = c_MSG_W - 1; i >= 0; i--) begin
            if (crc[31] ^ msg[i]) crc = {crc[30:0], 1'b0} ^ c_POLY;
            else                  crc = {crc[30:0], 1'b0};
        end
        return ~crc;
    endfunction

    logic [DLL_W-1:0] r_mem [DEPTH];
    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW-1:0]  r_rp_ptr;
    logic [c_CW-1:0]  r_rp_left;
    logic [c_CW-1:0]  r_count;
    logic [SEQ_W-1:0] r_next_seq;
    logic [SEQ_W-1:0] r_acked_seq;
    logic [c_TW-1:0]  r_timer;
    logic [1:0]       r_replay_num;
    logic             r_link_retrain;
    logic             r_dllp_err;
    logic             r_dll_valid;
    logic [DLL_W-1:0] r_dll_tlp;

    logic             w_out_free;
    logic             w_tl_ready;
    logic             w_tl_fire;
    logic             w_rp_load;
    logic [DLL_W-1:0] w_new_entry;
    logic [SEQ_W-1:0] w_dllp_seq;
    logic             w_is_ack;
    logic             w_is_nak;
    logic             w_dllp_hit;
    logic [SEQ_W-1:0] w_n;
    logic             w_n_bad;
    logic             w_purge;
    logic [c_CW-1:0]  w_n_eff;
    logic             w_progress;
    logic [c_CW-1:0]  w_count_next;
    logic [c_AW-1:0]  w_rd_ptr_next;
    logic             w_clamp;
    logic [c_CW-1:0]  w_rp_left_c;
    logic [c_AW-1:0]  w_rp_ptr_c;
    logic             w_expire;
    logic             w_nak_replay;
    logic             w_trigger;
    logic [1:0]       w_rn_base;
    logic             w_unused_dllp;

    assign w_unused_dllp = ^{dllp[47:32], dllp[23:12]};

    // ACK/NAK distance from the last acknowledged sequence number
    assign w_dllp_seq    = SEQ_W'(dllp[11:0]);
    assign w_is_ack      = dllp_valid && (dllp[31:24] == 8'h00);
    assign w_is_nak      = dllp_valid && (dllp[31:24] == 8'h10);
    assign w_dllp_hit    = w_is_ack || w_is_nak;
    assign w_n           = w_dllp_seq - r_acked_seq;
    assign w_n_bad       = w_n > SEQ_W'(r_count);
    assign w_purge       = w_dllp_hit && !w_n_bad;
    assign w_n_eff       = w_purge ? c_CW'(w_n) : '0;
    assign w_progress    = (w_n_eff != '0);

    assign w_out_free    = !r_dll_valid || dll_ready;
    assign w_tl_fire     = tl_valid && w_tl_ready;
    assign w_new_entry   = {r_next_seq, tl_tlp, f_lcrc({r_next_seq, tl_tlp})};
    assign w_count_next  = r_count + c_CW'(w_tl_fire) - w_n_eff;
    assign w_rd_ptr_next = r_rd_ptr + w_n_eff[c_AW-1:0];

    // A purge that overtakes the replay cursor drags the cursor to the new head
    assign w_clamp       = r_rp_left > w_count_next;
    assign w_rp_left_c   = w_clamp ? w_count_next  : r_rp_left;
    assign w_rp_ptr_c    = w_clamp ? w_rd_ptr_next : r_rp_ptr;

    assign w_expire      = (r_state == c_ST_NORMAL) && (r_count != '0) &&
                           !w_progress && (r_timer == c_TIMER_LAST);
    assign w_nak_replay  = (r_state == c_ST_NORMAL) && w_is_nak && w_purge &&
                           (w_count_next != '0);
    assign w_trigger     = w_expire || w_nak_replay;
    assign w_rn_base     = w_progress ? 2'd0 : r_replay_num;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_NORMAL;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_NORMAL: if (w_trigger) w_state_next = c_ST_REPLAY;
            c_ST_REPLAY: if ((w_count_next == '0) || ((w_rp_left_c == '0) && w_out_free))
                             w_state_next = c_ST_NORMAL;
            default:     w_state_next = c_ST_NORMAL;
        endcase
    end

    always_comb begin
        w_tl_ready = 1'b0;
        w_rp_load  = 1'b0;
        case (r_state)
            c_ST_NORMAL: w_tl_ready = (r_count < c_DEPTH_CNT) && w_out_free;
            c_ST_REPLAY: w_rp_load  = (w_rp_left_c != '0) && w_out_free;
            default:     w_tl_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_tl_fire) r_mem[r_wr_ptr] <= w_new_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dll_valid <= 1'b0;
            r_dll_tlp   <= '0;
        end else if (w_tl_fire) begin
            r_dll_valid <= 1'b1;
            r_dll_tlp   <= w_new_entry;
        end else if (w_rp_load) begin
            r_dll_valid <= 1'b1;
            r_dll_tlp   <= r_mem[w_rp_ptr_c];
        end else if (dll_ready) begin
            r_dll_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_rp_ptr       <= '0;
            r_rp_left      <= '0;
            r_count        <= '0;
            r_next_seq     <= '0;
            r_acked_seq    <= '1;
            r_timer        <= '0;
            r_replay_num   <= 2'd0;
            r_link_retrain <= 1'b0;
            r_dllp_err     <= 1'b0;
        end else begin
            if (w_tl_fire) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_next_seq <= r_next_seq + 1'b1;
            end
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_dllp_err  <= w_dllp_hit && w_n_bad;
            if (w_purge) r_acked_seq <= w_dllp_seq;

            if ((r_state == c_ST_NORMAL) && w_trigger) begin
                r_rp_ptr  <= w_rd_ptr_next;
                r_rp_left <= w_count_next;
            end else if (r_state == c_ST_REPLAY) begin
                r_rp_ptr  <= w_rp_ptr_c + c_AW'(w_rp_load);
                r_rp_left <= w_rp_left_c - c_CW'(w_rp_load);
            end

            if ((r_state == c_ST_NORMAL) && (r_count != '0))
                r_timer <= (w_progress || w_expire) ? '0 : r_timer + 1'b1;
            else
                r_timer <= '0;

            // Rollover from 3 still replays, but also asks for link retraining
            r_replay_num   <= w_trigger ? w_rn_base + 2'd1 : w_rn_base;
            r_link_retrain <= w_trigger && (w_rn_base == 2'd3);
        end
    end

    assign tl_ready     = w_tl_ready;
    assign dll_valid    = r_dll_valid;
    assign dll_tlp      = r_dll_tlp;
    assign next_seq     = r_next_seq;
    assign acked_seq    = r_acked_seq;
    assign buf_count    = r_count;
    assign replay_num   = r_replay_num;
    assign link_retrain = r_link_retrain;
    assign dllp_err     = r_dllp_err;

endmodule
`default_nettype wire

// File: tb/tb_pcie_dll_tx_replay.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcie_dll_tx_replay
//  Function : directed self-checking bench for pcie_dll_tx_replay
//  Revision : 1.0  initial release
// ============================================================================
module tb_pcie_dll_tx_replay;

    localparam int TLP_W = 224;
    localparam int SEQ_W = 12;
    localparam int DEPTH = 8;
    localparam int DLL_W = TLP_W + SEQ_W + 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             tl_valid;
    logic             tl_ready;
    logic [TLP_W-1:0] tl_tlp;
    logic             dll_valid;
    logic             dll_ready;
    logic [DLL_W-1:0] dll_tlp;
    logic             dllp_valid;
    logic [47:0]      dllp;
    logic [SEQ_W-1:0] next_seq;
    logic [SEQ_W-1:0] acked_seq;
    logic [3:0]       buf_count;
    logic [1:0]       replay_num;
    logic             link_retrain;
    logic             dllp_err;

    int total = 0;
    int bad   = 0;

    pcie_dll_tx_replay #(
        .TLP_W(TLP_W), .SEQ_W(SEQ_W), .DEPTH(DEPTH), .REPLAY_TIMEOUT(256)
    ) dut (
        .clk(clk), .rst(rst), .tl_valid(tl_valid), .tl_ready(tl_ready),
        .tl_tlp(tl_tlp), .dll_valid(dll_valid), .dll_ready(dll_ready),
        .dll_tlp(dll_tlp), .dllp_valid(dllp_valid), .dllp(dllp),
        .next_seq(next_seq), .acked_seq(acked_seq), .buf_count(buf_count),
        .replay_num(replay_num), .link_retrain(link_retrain), .dllp_err(dllp_err)
    );

    always #5 clk = ~clk;

    // Reference CRC: plain long division of the message, MSB first
    function automatic logic [31:0] crc_model(input logic [255:0] d, input int nbits);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = nbits - 1; i >= 0; i--)
            c = (c << 1) ^ (((c[31] ^ d[i]) == 1'b1) ? 32'h04C1_1DB7 : 32'h0);
        return ~c;
    endfunction

    function automatic logic [TLP_W-1:0] tlp_pat(input logic [11:0] s);
        logic [TLP_W-1:0] p;
        for (int w = 0; w < 7; w++)
            p[w*32 +: 32] = {s, 4'(w), 16'h5A3C} ^ (32'h9E37_79B9 * (w + 1));
        return p;
    endfunction

    function automatic logic [DLL_W-1:0] exp_dll(input logic [11:0] s);
        logic [TLP_W-1:0] p;
        p = tlp_pat(s);
        return {s, p, crc_model({20'h0, s, p}, SEQ_W + TLP_W)};
    endfunction

    task automatic send_tlp(input logic [11:0] s);
        tl_valid = 1'b1;
        tl_tlp   = tlp_pat(s);
        for (int k = 0; k < 64 && !tl_ready; k++) @(negedge clk);
        if (!tl_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: tl_ready=%0b required=1 seq=%0d", tl_ready, s);
        end
        @(negedge clk);
        tl_valid = 1'b0;
    endtask

    task automatic send_dllp(input logic [7:0] code, input logic [11:0] s);
        dllp       = {16'hBEEF, code, 12'h000, s};
        dllp_valid = 1'b1;
        @(negedge clk);
        dllp_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tl_valid = 1'b0; dllp_valid = 1'b0; dll_ready = 1'b1;
        tl_tlp = '0; dllp = '0;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        logic [71:0] ref_msg;
        do_reset();
        total++; if (dll_valid !== 1'b0) begin bad++; $display("FAIL rst_dll_valid: got %0b want 0", dll_valid); end
        total++; if (dll_tlp !== '0) begin bad++; $display("FAIL rst_dll_tlp: got %0h want 0", dll_tlp); end
        total++; if (next_seq !== 12'd0) begin bad++; $display("FAIL rst_next_seq: got %0d want 0", next_seq); end
        total++; if (acked_seq !== 12'hFFF) begin bad++; $display("FAIL rst_acked_seq: got %0h want fff", acked_seq); end
        total++; if (buf_count !== 4'd0) begin bad++; $display("FAIL rst_buf_count: got %0d want 0", buf_count); end
        total++; if ({replay_num, link_retrain, dllp_err} !== 4'b0) begin bad++;
            $display("FAIL rst_flags: got rn=%0d lr=%0b err=%0b want 0", replay_num, link_retrain, dllp_err); end
        rst = 1'b0;
        ref_msg = "123456789";
        total++; if (crc_model({184'h0, ref_msg}, 72) !== 32'hFC89_1918) begin bad++;
            $display("FAIL crc_model_check: got %0h want fc891918", crc_model({184'h0, ref_msg}, 72)); end
    endtask

    task automatic test_send3();
        for (int i = 0; i < 3; i++) begin
            send_tlp(12'(i));
            total++; if (dll_valid !== 1'b1 || dll_tlp[DLL_W-1 -: SEQ_W] !== 12'(i)) begin bad++;
                $display("FAIL send3_seq: got v=%0b seq=%0d want v=1 seq=%0d", dll_valid, dll_tlp[DLL_W-1 -: SEQ_W], i); end
            total++; if (dll_tlp !== exp_dll(12'(i))) begin bad++;
                $display("FAIL send3_frame: got %0h want %0h", dll_tlp, exp_dll(12'(i))); end
        end
        @(negedge clk);
        total++; if (next_seq !== 12'd3 || buf_count !== 4'd3 || dll_valid !== 1'b0) begin bad++;
            $display("FAIL send3_state: got ns=%0d cnt=%0d v=%0b want 3 3 0", next_seq, buf_count, dll_valid); end
    endtask

    task automatic test_ack();
        send_dllp(8'h00, 12'd1);
        total++; if (buf_count !== 4'd1 || acked_seq !== 12'd1 || replay_num !== 2'd0) begin bad++;
            $display("FAIL ack1: got cnt=%0d ack=%0d rn=%0d want 1 1 0", buf_count, acked_seq, replay_num); end
        send_dllp(8'h00, 12'd7);
        total++; if (dllp_err !== 1'b1 || buf_count !== 4'd1 || acked_seq !== 12'd1) begin bad++;
            $display("FAIL ack_range: got err=%0b cnt=%0d ack=%0d want 1 1 1", dllp_err, buf_count, acked_seq); end
        @(negedge clk);
        total++; if (dllp_err !== 1'b0) begin bad++; $display("FAIL err_pulse: got %0b want 0", dllp_err); end
        send_dllp(8'h20, 12'd2);
        total++; if (buf_count !== 4'd1 || acked_seq !== 12'd1) begin bad++;
            $display("FAIL ignored_code: got cnt=%0d ack=%0d want 1 1", buf_count, acked_seq); end
        send_dllp(8'h00, 12'd2);
        total++; if (buf_count !== 4'd0 || acked_seq !== 12'd2) begin bad++;
            $display("FAIL ack_all: got cnt=%0d ack=%0d want 0 2", buf_count, acked_seq); end
    endtask

    task automatic test_fill();
        for (int i = 3; i < 11; i++) send_tlp(12'(i));
        tl_valid = 1'b1;
        tl_tlp   = tlp_pat(12'd11);
        total++; if (buf_count !== 4'd8 || tl_ready !== 1'b0) begin bad++;
            $display("FAIL fill_full: got cnt=%0d rdy=%0b want 8 0", buf_count, tl_ready); end
        @(negedge clk);
        total++; if (next_seq !== 12'd11) begin bad++; $display("FAIL fill_block: got ns=%0d want 11", next_seq); end
        send_dllp(8'h00, 12'd6);
        tl_valid = 1'b0;
        total++; if (buf_count !== 4'd4 || tl_ready !== 1'b1) begin bad++;
            $display("FAIL fill_release: got cnt=%0d rdy=%0b want 4 1", buf_count, tl_ready); end
        send_dllp(8'h00, 12'd10);
    endtask

    task automatic test_nak_replay();
        logic [DLL_W-1:0] held;
        bit               have_held;
        int               beats;
        beats = 0; have_held = 0; held = '0;
        for (int i = 11; i < 16; i++) send_tlp(12'(i));
        send_dllp(8'h10, 12'd12);
        total++; if (replay_num !== 2'd1 || buf_count !== 4'd3 || acked_seq !== 12'd12 || tl_ready !== 1'b0) begin bad++;
            $display("FAIL nak_enter: got rn=%0d cnt=%0d ack=%0d rdy=%0b want 1 3 12 0", replay_num, buf_count, acked_seq, tl_ready); end
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (have_held) begin
                total++; if (dll_valid !== 1'b1 || dll_tlp !== held) begin bad++;
                    $display("FAIL replay_hold: got v=%0b %0h want v=1 %0h", dll_valid, dll_tlp, held); end
                have_held = 0;
            end
            dll_ready = (cyc != 2);
            if (dll_valid && dll_ready) begin
                total++; if (dll_tlp !== exp_dll(12'(13 + beats)) || tl_ready !== 1'b0) begin bad++;
                    $display("FAIL replay_beat: got %0h rdy=%0b want %0h rdy=0", dll_tlp, tl_ready, exp_dll(12'(13 + beats))); end
                beats++;
            end else if (dll_valid) begin
                held = dll_tlp; have_held = 1;
            end
            @(negedge clk);
        end
        dll_ready = 1'b1;
        total++; if (beats !== 3 || tl_ready !== 1'b1 || buf_count !== 4'd3) begin bad++;
            $display("FAIL replay_done: got beats=%0d rdy=%0b cnt=%0d want 3 1 3", beats, tl_ready, buf_count); end
        send_dllp(8'h00, 12'd15);
        total++; if (buf_count !== 4'd0 || replay_num !== 2'd0) begin bad++;
            $display("FAIL replay_ack: got cnt=%0d rn=%0d want 0 0", buf_count, replay_num); end
    endtask

    task automatic test_timer();
        int         chg [8];
        int         nchg, nretrain, retrain_idx, beats, tail;
        logic [1:0] prev;
        nchg = 0; nretrain = 0; retrain_idx = -1; beats = 0; tail = 0;
        send_tlp(12'd16);
        send_tlp(12'd17);
        @(negedge clk);
        prev = replay_num;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            if (replay_num !== prev) begin
                if (nchg < 8) chg[nchg] = int'(replay_num);
                nchg++;
                prev = replay_num;
            end
            if (link_retrain) begin nretrain++; retrain_idx = nchg; end
            if (dll_valid) begin
                total++; if (dll_tlp !== exp_dll(12'(16 + beats % 2))) begin bad++;
                    $display("FAIL timer_beat: got %0h want %0h", dll_tlp, exp_dll(12'(16 + beats % 2))); end
                beats++;
            end
            if (nchg >= 4) tail++;
            if (tail > 12) break;
            @(negedge clk);
        end
        total++; if (nchg !== 4 || chg[0] !== 1 || chg[1] !== 2 || chg[2] !== 3 || chg[3] !== 0) begin bad++;
            $display("FAIL timer_rn_seq: got n=%0d %0d,%0d,%0d,%0d want 4 1,2,3,0", nchg, chg[0], chg[1], chg[2], chg[3]); end
        total++; if (nretrain !== 1 || retrain_idx !== 4) begin bad++;
            $display("FAIL timer_retrain: got pulses=%0d at=%0d want 1 at 4", nretrain, retrain_idx); end
        total++; if (beats !== 8) begin bad++; $display("FAIL timer_beats: got %0d want 8", beats); end
        send_dllp(8'h00, 12'd17);
        total++; if (buf_count !== 4'd0 || replay_num !== 2'd0) begin bad++;
            $display("FAIL timer_ack: got cnt=%0d rn=%0d want 0 0", buf_count, replay_num); end
    endtask

    task automatic test_wrap();
        logic [11:0] s;
        do_reset();
        rst = 1'b0;
        for (int b = 0; b < 2047; b++) begin
            send_tlp(12'(2 * b));
            send_tlp(12'(2 * b + 1));
            send_dllp(8'h00, 12'(2 * b + 1));
        end
        total++; if (next_seq !== 12'd4094 || buf_count !== 4'd0) begin bad++;
            $display("FAIL wrap_pump: got ns=%0d cnt=%0d want 4094 0", next_seq, buf_count); end
        s = 12'd4094;
        for (int i = 0; i < 4; i++) begin
            send_tlp(s);
            total++; if (dll_tlp !== exp_dll(s)) begin bad++;
                $display("FAIL wrap_frame: got seq=%0d %0h want seq=%0d", dll_tlp[DLL_W-1 -: SEQ_W], dll_tlp, s); end
            s = s + 12'd1;
        end
        send_dllp(8'h00, 12'd0);
        total++; if (buf_count !== 4'd1 || acked_seq !== 12'd0 || next_seq !== 12'd2) begin bad++;
            $display("FAIL wrap_ack: got cnt=%0d ack=%0d ns=%0d want 1 0 2", buf_count, acked_seq, next_seq); end
    endtask

    task automatic test_mid_reset();
        dll_ready = 1'b0;
        send_tlp(12'd2);
        rst = 1'b1;
        @(negedge clk);
        total++; if (dll_valid !== 1'b0 || dll_tlp !== '0 || buf_count !== 4'd0 ||
                     next_seq !== 12'd0 || acked_seq !== 12'hFFF || replay_num !== 2'd0) begin bad++;
            $display("FAIL mid_reset: got v=%0b cnt=%0d ns=%0d ack=%0h rn=%0d want 0 0 0 fff 0",
                     dll_valid, buf_count, next_seq, acked_seq, replay_num); end
        rst = 1'b0;
        dll_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_send3();
        test_ack();
        test_fill();
        test_nak_replay();
        test_timer();
        test_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
